// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, width helper and default sizing for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {IDLE, RESET_HOLD, WAIT_LOCK, STABLE, RUN, FAULT} state_t;

    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_RESET_CYCLES  = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_STABLE_CYCLES = 256;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = width_for(DEF_LOCK_TIMEOUT);
    localparam int DEF_RETRY_W       = width_for(DEF_MAX_RETRIES);

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: enable/status/PLL-control bundle; slave is the sequencer, master its environment.
interface pll_reset_sequencer_if
    import pll_seq_pkg::*;
#(
    parameter int RETRY_W = DEF_RETRY_W
);
    logic               enable;
    logic               clear_status;
    logic               pll_lock_async;
    logic               pll_resetb;
    logic               pll_bypass;
    logic               rst_out_n;
    logic               locked;
    logic               fault;
    logic               lock_lost;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        output enable, clear_status, pll_lock_async,
        input  pll_resetb, pll_bypass, rst_out_n, locked, fault, lock_lost, retry_cnt
    );

    modport slave (
        input  enable, clear_status, pll_lock_async,
        output pll_resetb, pll_bypass, rst_out_n, locked, fault, lock_lost, retry_cnt
    );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta, r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives PLL RESETB/BYPASS and releases the fabric reset once lock is stable.
// PLL_SEQ_BYPASS_FALLBACK_EN: on FAULT, bypass the PLL and release the fabric on the reference clock.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int RETRY_W       = DEF_RETRY_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_reset_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0]   RH_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   ST_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    localparam logic FALLBACK = 1'b1;
`else
    localparam logic FALLBACK = 1'b0;
`endif

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [RETRY_W-1:0] r_retry, w_retry;
    logic               w_lock_s, w_lost_evt;
    logic               r_lock_lost, r_pll_resetb, r_pll_bypass, r_rst_out_n, r_locked, r_fault;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.pll_lock_async),
        .o_q   (w_lock_s)
    );

    always_comb begin
        w_next     = r_state;
        w_retry    = r_retry;
        w_lost_evt = 1'b0;
        if (!bus.enable) begin
            w_next  = IDLE;
            w_retry = '0;
        end else begin
            case (r_state)
                IDLE:       w_next = RESET_HOLD;
                RESET_HOLD: w_next = (r_cnt == RH_LAST) ? WAIT_LOCK : RESET_HOLD;
                WAIT_LOCK: begin
                    // a lock arriving on the timeout edge still wins
                    if (w_lock_s) begin
                        w_next = STABLE;
                    end else if (r_cnt == TO_LAST) begin
                        w_next  = (r_retry < RETRY_MAX) ? RESET_HOLD : FAULT;
                        w_retry = (r_retry < RETRY_MAX) ? r_retry + 1'b1 : r_retry;
                    end
                end
                STABLE: begin
                    w_next  = !w_lock_s ? WAIT_LOCK : (r_cnt == ST_LAST) ? RUN : STABLE;
                    w_retry = (w_lock_s && r_cnt == ST_LAST) ? '0 : r_retry;
                end
                RUN: begin
                    w_next     = w_lock_s ? RUN : RESET_HOLD;
                    w_lost_evt = !w_lock_s;
                end
                FAULT:   w_next = FAULT;
                default: w_next = IDLE;
            endcase
        end
        w_cnt = (w_next != r_state) ? '0 :
                (r_state inside {RESET_HOLD, WAIT_LOCK, STABLE}) ? r_cnt + 1'b1 : r_cnt;
    end

    // outputs are decoded from the next state so they change on the transition edge itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_retry      <= '0;
            r_lock_lost  <= 1'b0;
            r_pll_resetb <= 1'b0;
            r_pll_bypass <= 1'b0;
            r_rst_out_n  <= 1'b0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt;
            r_retry      <= w_retry;
            r_lock_lost  <= w_lost_evt | (r_lock_lost & ~bus.clear_status);
            r_pll_resetb <= w_next inside {WAIT_LOCK, STABLE, RUN};
            r_pll_bypass <= FALLBACK & (w_next == FAULT);
            r_rst_out_n  <= (w_next == RUN) | (FALLBACK & (w_next == FAULT));
            r_locked     <= w_next == RUN;
            r_fault      <= w_next == FAULT;
        end
    end

    assign bus.pll_resetb = r_pll_resetb;
    assign bus.pll_bypass = r_pll_bypass;
    assign bus.rst_out_n  = r_rst_out_n;
    assign bus.locked     = r_locked;
    assign bus.fault      = r_fault;
    assign bus.lock_lost  = r_lock_lost;
    assign bus.retry_cnt  = r_retry;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: randomized scenario timing; expected output-change events are scheduled
// arithmetically from the sequencing rules and matched by a monitor on every output change.
module tb_pll_reset_sequencer;
    localparam int R = 4, T = 20, S = 8, M = 2;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pll_reset_sequencer_if #(.RETRY_W(2)) bus();

    pll_reset_sequencer #(
        .RESET_CYCLES  (R),
        .LOCK_TIMEOUT  (T),
        .STABLE_CYCLES (S),
        .MAX_RETRIES   (M),
        .CNT_W         (16),
        .RETRY_W       (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {int c; logic [7:0] v;} ev_t;
    ev_t q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] outs;
    assign outs = {bus.pll_resetb, bus.pll_bypass, bus.rst_out_n, bus.locked,
                   bus.fault, bus.lock_lost, bus.retry_cnt};

    // {pll_resetb, pll_bypass, rst_out_n, locked, fault, lock_lost, retry_cnt}
    function automatic logic [7:0] ov(input logic rb, bp, ro, lk, ft, ll, input int rc);
        logic [1:0] r2;
        r2 = 2'(rc);
        return {rb, bp, ro, lk, ft, ll, r2};
    endfunction

    task automatic sched(input int c, input logic [7:0] v);
        ev_t e;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        logic [7:0] prev;
        ev_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (outs !== prev) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b, required no change from %b", cyc, outs, prev);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.v !== outs) begin
                        n_bad++;
                        $display("FAIL output_event cyc=%0d got=%b, required %b at cyc %0d", cyc, outs, e.v, e.c);
                    end
                end
                prev = outs;
            end
        end
    end

    initial begin
        int c, e, n, d, g, w, a, k;
        bus.enable = 1'b0;
        bus.clear_status = 1'b0;
        bus.pll_lock_async = 1'b0;
        for (int it = 0; it < 3; it++) begin
            rst_n = 1'b0;
            bus.enable = 1'b0;
            bus.clear_status = 1'b0;
            bus.pll_lock_async = 1'b0;
            repeat (2) @(negedge clk);
            n_cmp++;
            if (outs !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_state got=%b, required 00000000", outs);
            end
            // bring-up: resetb low R cycles, release S+2 edges after lock is first sampled
            c = cyc;
            rst_n = 1'b1;
            bus.enable = 1'b1;
            e = c + 1 + R;
            sched(e, ov(1, 0, 0, 0, 0, 0, 0));
            d = int'($urandom_range(1, 15));
            n = e + d;
            wait_to(n - 1);
            bus.pll_lock_async = 1'b1;
            sched(n + S + 2, ov(1, 0, 1, 1, 0, 0, 0));
            wait_to(n + S + 2 + int'($urandom_range(1, 5)));
            // lock loss in RUN, with a clear_status landing on the same edge
            c = cyc;
            bus.pll_lock_async = 1'b0;
            sched(c + 3, ov(0, 0, 0, 0, 0, 1, 0));
            e = c + 3 + R;
            sched(e, ov(1, 0, 0, 0, 0, 1, 0));
            wait_to(c + 2);
            bus.clear_status = 1'b1;
            @(negedge clk);
            bus.clear_status = 1'b0;
            // relock with a 2-cycle glitch during STABLE
            d = int'($urandom_range(1, 15));
            n = e + d;
            wait_to(n - 1);
            bus.pll_lock_async = 1'b1;
            g = int'($urandom_range(0, 6));
            wait_to(n + g);
            bus.pll_lock_async = 1'b0;
            wait_to(n + g + 2);
            bus.pll_lock_async = 1'b1;
            sched(n + g + 5 + S, ov(1, 0, 1, 1, 0, 1, 0));
            wait_to(n + g + 5 + S + int'($urandom_range(0, 3)));
            c = cyc;
            bus.clear_status = 1'b1;
            sched(c + 1, ov(1, 0, 1, 1, 0, 0, 0));
            @(negedge clk);
            bus.clear_status = 1'b0;
            // enable=0 from RUN, then again mid-WAIT_LOCK
            wait_to(cyc + int'($urandom_range(1, 4)));
            c = cyc;
            bus.enable = 1'b0;
            bus.pll_lock_async = 1'b0;
            sched(c + 1, 8'h00);
            wait_to(c + 1 + int'($urandom_range(1, 3)));
            c = cyc;
            bus.enable = 1'b1;
            e = c + 1 + R;
            sched(e, ov(1, 0, 0, 0, 0, 0, 0));
            w = int'($urandom_range(0, T - 3));
            wait_to(e + w);
            bus.enable = 1'b0;
            sched(e + w + 1, 8'h00);
            // lock never arrives: M retries, then FAULT on timeout M+1
            wait_to(cyc + 2);
            c = cyc;
            bus.enable = 1'b1;
            a = c + 1 + R;
            for (int r = 0; r <= M; r++) begin
                sched(a, ov(1, 0, 0, 0, 0, 0, r));
                if (r < M) sched(a + T, ov(0, 0, 0, 0, 0, 0, r + 1));
                else sched(a + T, ov(0, BYP, BYP, 0, 1, 0, r));
                if (r < M) a = a + T + R;
            end
            wait_to(a + T + int'($urandom_range(1, 5)));
            c = cyc;
            bus.enable = 1'b0;
            bus.pll_lock_async = 1'b1;
            sched(c + 1, 8'h00);
            // async reset while in STABLE
            wait_to(c + 3);
            c = cyc;
            bus.enable = 1'b1;
            e = c + 1 + R;
            sched(e, ov(1, 0, 0, 0, 0, 0, 0));
            k = int'($urandom_range(0, S - 2));
            wait_to(e + 1 + k);
            #2;
            rst_n = 1'b0;
            bus.enable = 1'b0;
            #1;
            n_cmp++;
            if (outs !== 8'h00) begin
                n_bad++;
                $display("FAIL async_reset got=%b, required 00000000", outs);
            end
            sched(cyc + 1, 8'h00);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events got=%0d pending, required 0 (next at cyc %0d)", q.size(), q[0].c);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
